// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the mantissa-multiplier control sequencer.
// Optional zero-skip path is enabled with the MUL_ZERO_SKIP_EN macro.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_ADD    = 2'd2,
    ST_DONE   = 2'd3
  } mul_state_t;

  localparam int MUL_NUM_STAGES = 7;
  localparam int MUL_ADD_CYCLES = 2;

  localparam int REQ_MUL = 0;
  localparam int REQ_AUX = 1;

endpackage

// File: rtl/mul_rr_arbiter2.sv
// Two-way round-robin grant. Purely combinational; the parent owns the
// last-grant register and updates it on the accepting handshake.
module mul_rr_arbiter2
  import mul_ctrl_pkg::*;
(
  input  logic [1:0] i_req_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  logic w_both;

  assign w_both = i_req_valid[REQ_MUL] & i_req_valid[REQ_AUX];

  always_comb begin
    o_grant     = 2'b00;
    o_grant_idx = 1'b0;
    if (w_both) begin
      // Contention: the requester not served last time wins.
      o_grant_idx = ~i_last_grant;
    end else begin
      o_grant_idx = i_req_valid[REQ_AUX];
    end
    if (|i_req_valid) begin
      o_grant[o_grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/mul_reduction_sequencer.sv
// Sequences the mantissa multiplier: arbitrate, step the compressor stages,
// run the final adder, then hold the result. MUL_ZERO_SKIP_EN adds zero bypass.
module mul_reduction_sequencer
  import mul_ctrl_pkg::*;
#(
  parameter int NUM_STAGES = MUL_NUM_STAGES,
  parameter int ADD_CYCLES = MUL_ADD_CYCLES,
  parameter int STAGE_W    = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [1:0]         i_req_valid,
  output logic [1:0]         o_req_ready,
  output logic               o_result_valid,
  input  logic               i_result_ready,
  output logic               o_result_owner,
  output logic               o_operand_load,
  output logic               o_operand_sel,
  output logic               o_stage_en,
  output logic [STAGE_W-1:0] o_stage_sel,
  output logic               o_add_en,
  output logic               o_result_latch,
  output logic               o_busy,
`ifdef MUL_ZERO_SKIP_EN
  input  logic [1:0]         i_operand_zero,
  output logic               o_zero_result,
`endif
  output mul_state_t         o_dbg_state,
  output logic               o_dbg_last_grant
);

  localparam logic [STAGE_W-1:0] LP_STAGE_LAST = STAGE_W'(NUM_STAGES - 1);
  localparam logic [1:0]         LP_ADD_LAST   = 2'(ADD_CYCLES - 1);

  mul_state_t         r_state;
  mul_state_t         w_next;
  logic               r_last_grant;
  logic               r_owner;
  logic [STAGE_W-1:0] r_stage_cnt;
  logic [1:0]         r_add_cnt;
  logic [1:0]         w_grant;
  logic               w_grant_idx;
  logic [1:0]         w_ready;
  logic               w_hs;
  logic               w_skip;
`ifdef MUL_ZERO_SKIP_EN
  logic               r_zero;
`endif

  mul_rr_arbiter2 u_arb (
    .i_req_valid  (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_grant_idx  (w_grant_idx)
  );

  // Handshake: valid/ready both high in IDLE on a rising edge accepts the
  // request. Ready is offered only in IDLE and never while reset is asserted,
  // so an unaccepted request leaves no trace.
  assign w_ready = (r_state == ST_IDLE && !i_reset) ? w_grant : 2'b00;
  assign w_hs    = |(i_req_valid & w_ready);

`ifdef MUL_ZERO_SKIP_EN
  assign w_skip = i_operand_zero[w_grant_idx];
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_next         = r_state;
    o_req_ready    = 2'b00;
    o_result_valid = 1'b0;
    o_result_owner = 1'b0;
    o_operand_load = 1'b0;
    o_operand_sel  = 1'b0;
    o_stage_en     = 1'b0;
    o_stage_sel    = '0;
    o_add_en       = 1'b0;
    o_result_latch = 1'b0;
`ifdef MUL_ZERO_SKIP_EN
    o_zero_result  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        o_req_ready    = w_ready;
        o_operand_load = w_hs;
        o_operand_sel  = w_hs & w_grant_idx;
        if (w_hs) begin
          w_next = w_skip ? ST_DONE : ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        o_stage_en  = 1'b1;
        o_stage_sel = r_stage_cnt;
        if (r_stage_cnt == LP_STAGE_LAST) begin
          w_next = ST_ADD;
        end
      end
      ST_ADD: begin
        o_add_en = 1'b1;
        if (r_add_cnt == LP_ADD_LAST) begin
          o_result_latch = 1'b1;
          w_next         = ST_DONE;
        end
      end
      ST_DONE: begin
        o_result_valid = 1'b1;
        o_result_owner = r_owner;
`ifdef MUL_ZERO_SKIP_EN
        o_zero_result  = r_zero;
`endif
        if (i_result_ready) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_stage_cnt  <= '0;
      r_add_cnt    <= 2'd0;
`ifdef MUL_ZERO_SKIP_EN
      r_zero       <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_last_grant <= w_grant_idx;
            r_owner      <= w_grant_idx;
            r_stage_cnt  <= '0;
`ifdef MUL_ZERO_SKIP_EN
            r_zero       <= w_skip;
`endif
          end
        end
        ST_REDUCE: begin
          // Counter stops at the terminal value instead of wrapping.
          if (r_stage_cnt == LP_STAGE_LAST) begin
            r_add_cnt <= 2'd0;
          end else begin
            r_stage_cnt <= r_stage_cnt + 1'b1;
          end
        end
        ST_ADD: begin
          if (r_add_cnt != LP_ADD_LAST) begin
            r_add_cnt <= r_add_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy           = (r_state != ST_IDLE);
  assign o_dbg_state      = r_state;
  assign o_dbg_last_grant = r_last_grant;

endmodule

// File: tb/tb_mul_reduction_sequencer.sv
// Directed bench for mul_reduction_sequencer: timing of the full sequence,
// round-robin order, result hold, mid-op reset, dropped requests, zero skip.
module tb_mul_reduction_sequencer;
  import mul_ctrl_pkg::*;

  localparam int NS = 7;
  localparam int AC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic       result_ready;
  logic [1:0] req_ready;
  logic       result_valid;
  logic       result_owner;
  logic       operand_load;
  logic       operand_sel;
  logic       stage_en;
  logic [3:0] stage_sel;
  logic       add_en;
  logic       result_latch;
  logic       busy;
  mul_state_t dbg_state;
  logic       dbg_last_grant;
`ifdef MUL_ZERO_SKIP_EN
  logic [1:0] operand_zero;
  logic       zero_result;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  mul_reduction_sequencer #(.NUM_STAGES(NS), .ADD_CYCLES(AC), .STAGE_W(4)) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_req_valid      (req_valid),
    .o_req_ready      (req_ready),
    .o_result_valid   (result_valid),
    .i_result_ready   (result_ready),
    .o_result_owner   (result_owner),
    .o_operand_load   (operand_load),
    .o_operand_sel    (operand_sel),
    .o_stage_en       (stage_en),
    .o_stage_sel      (stage_sel),
    .o_add_en         (add_en),
    .o_result_latch   (result_latch),
    .o_busy           (busy),
`ifdef MUL_ZERO_SKIP_EN
    .i_operand_zero   (operand_zero),
    .o_zero_result    (zero_result),
`endif
    .o_dbg_state      (dbg_state),
    .o_dbg_last_grant (dbg_last_grant)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_valid"}, 32'(result_valid), 32'd0);
    chk({tag, "_load"}, 32'(operand_load), 32'd0);
    chk({tag, "_stage_en"}, 32'(stage_en), 32'd0);
    chk({tag, "_stage_sel"}, 32'(stage_sel), 32'd0);
    chk({tag, "_add_en"}, 32'(add_en), 32'd0);
    chk({tag, "_latch"}, 32'(result_latch), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // One complete operation starting in IDLE. vld is driven for the grant and
  // then held if keep is set; pulse_at >= 0 pulses requester 0 during REDUCE.
  task automatic full_op(input logic [1:0] vld, input logic exp_idx, input int hold,
                         input logic keep, input int pulse_at);
    logic [1:0] exp_ready;
    exp_ready = exp_idx ? 2'b10 : 2'b01;
    req_valid = vld;
    #1;
    chk("grant_ready", 32'(req_ready), 32'(exp_ready));
    chk("grant_load", 32'(operand_load), 32'd1);
    chk("grant_sel", 32'(operand_sel), 32'(exp_idx));
    tick;
    if (!keep) req_valid = 2'b00;
    for (int i = 0; i < NS; i++) begin
      if (i == pulse_at) req_valid = 2'b01;
      else if (!keep) req_valid = 2'b00;
      #1;
      chk("reduce_en", 32'(stage_en), 32'd1);
      chk("reduce_sel", 32'(stage_sel), 32'(i));
      chk("reduce_ready", 32'(req_ready), 32'd0);
      chk("reduce_add_en", 32'(add_en), 32'd0);
      tick;
    end
    if (!keep) req_valid = 2'b00;
    for (int a = 0; a < AC; a++) begin
      #1;
      chk("add_en", 32'(add_en), 32'd1);
      chk("add_latch", 32'(result_latch), 32'(a == AC - 1));
      chk("add_stage_en", 32'(stage_en), 32'd0);
      tick;
    end
    #1;
    chk("done_valid", 32'(result_valid), 32'd1);
    chk("done_owner", 32'(result_owner), 32'(exp_idx));
    chk("done_ready", 32'(req_ready), 32'd0);
`ifdef MUL_ZERO_SKIP_EN
    chk("done_zero", 32'(zero_result), 32'd0);
`endif
    for (int h = 0; h < hold; h++) begin
      tick;
      #1;
      chk("hold_valid", 32'(result_valid), 32'd1);
      chk("hold_owner", 32'(result_owner), 32'(exp_idx));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_state", 32'(dbg_state), 32'(ST_DONE));
    end
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    #1;
    chk("accept_valid", 32'(result_valid), 32'd0);
    chk("accept_busy", 32'(busy), 32'd0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = 2'b00;
    result_ready = 1'b0;
    repeat (2) tick;
    rst = 1'b0;
    #1;
  endtask

  initial begin
`ifdef MUL_ZERO_SKIP_EN
    operand_zero = 2'b00;
`endif
    // Reset state
    do_reset();
    chk_quiet("reset");
    chk("reset_last_grant", 32'(dbg_last_grant), 32'd1);

    // Single requester 0, full timing
    full_op(2'b01, 1'b0, 0, 1'b0, -1);
    chk_quiet("after_op1");

    // Both requesting: 0, 1, then 0 again
    do_reset();
    full_op(2'b11, 1'b0, 0, 1'b1, -1);
    #1;
    chk("rr_second_ready", 32'(req_ready), 32'b10);
    full_op(2'b11, 1'b1, 0, 1'b1, -1);
    full_op(2'b11, 1'b0, 0, 1'b1, -1);
    req_valid = 2'b00;
    #1;
    chk("rr_last_grant", 32'(dbg_last_grant), 32'd0);

    // Result held for 5 cycles without ResultReady, requester 1 alone
    tick;
    full_op(2'b10, 1'b1, 5, 1'b0, -1);

    // Reset in the middle of REDUCE
    do_reset();
    req_valid = 2'b01;
    tick;
    req_valid = 2'b00;
    repeat (3) tick;
    #1;
    chk("pre_reset_sel", 32'(stage_sel), 32'd3);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk_quiet("midop_reset");
    chk("midop_last_grant", 32'(dbg_last_grant), 32'd1);
    full_op(2'b10, 1'b1, 0, 1'b0, -1);

    // Short pulse during REDUCE is never granted
    full_op(2'b01, 1'b0, 0, 1'b0, 2);
    req_valid = 2'b00;
    #1;
    chk_quiet("dropped_pulse");
    tick;
    #1;
    chk_quiet("dropped_pulse_next");

`ifdef MUL_ZERO_SKIP_EN
    // Zero operand on requester 1 bypasses the datapath
    do_reset();
    operand_zero = 2'b10;
    req_valid = 2'b10;
    #1;
    chk("zero_grant", 32'(req_ready), 32'b10);
    tick;
    req_valid = 2'b00;
    operand_zero = 2'b00;
    #1;
    chk("zero_valid", 32'(result_valid), 32'd1);
    chk("zero_flag", 32'(zero_result), 32'd1);
    chk("zero_owner", 32'(result_owner), 32'd1);
    chk("zero_stage_en", 32'(stage_en), 32'd0);
    chk("zero_add_en", 32'(add_en), 32'd0);
    chk("zero_latch", 32'(result_latch), 32'd0);
    result_ready = 1'b1;
    tick;
    result_ready = 1'b0;
    #1;
    chk_quiet("zero_after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_reduction_sequencer.md
Name: mul_reduction_sequencer

Overview:
- Control sequencer for the floating-point unit's mantissa multiplier.
- Arbitrates between two requesters (0 = MUL issue, 1 = FMA/DIV helper) with round-robin priority.
- Steps the externally instantiated reduction tree through its compressor stages (per-bit full/half-adder columns), then through the final carry-propagate adder.
- Holds the result until the owner accepts it.

Parameters:
- NUM_STAGES, 7, compressor-tree reduction stages sequenced per operation (legal 1..15).
- ADD_CYCLES, 2, cycles the final carry-propagate adder needs (legal 1..4).
- STAGE_W, 4, width of StageSel; must satisfy 2**STAGE_W >= NUM_STAGES.

Ports:
- Clock  in  1  single clock; everything updates on the rising edge.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  2  per-requester operation request.
- ReqReady  out  2  per-requester grant/accept; one-hot or zero.
- ResultValid  out  1  result available in the datapath result register.
- ResultReady  in  1  consumer accepts the result.
- ResultOwner  out  1  index of the requester owning the current result.
- OperandLoad  out  1  datapath captures the granted requester's operands at this edge.
- OperandSel  out  1  operand mux select, equal to the granted index.
- StageEn  out  1  reduction stage register enable.
- StageSel  out  STAGE_W  current reduction stage index.
- AddEn  out  1  final adder pipeline enable.
- ResultLatch  out  1  datapath result register load.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Reset value of all outputs and registers: 0. State = IDLE. LastGrant = 1, so requester 0 wins first.
- Reset asserted in any state aborts the operation. At the next edge: state = IDLE, all outputs 0, no ResultValid.
- States: IDLE, REDUCE, ADD, DONE.
- IDLE:
  - ReqReady is combinational from ReqValid. With one requester valid, it is granted. With both valid, the requester != LastGrant is granted.
  - OperandLoad = |(ReqValid & ReqReady). OperandSel = granted index.
  - On the handshake edge: LastGrant and Owner <= granted index, StageCnt <= 0, state -> REDUCE.
- REDUCE:
  - StageEn = 1, StageSel = StageCnt, StageCnt increments each cycle.
  - When StageCnt == NUM_STAGES-1: AddCnt <= 0, state -> ADD.
- ADD:
  - AddEn = 1. ResultLatch = 1 only when AddCnt == ADD_CYCLES-1.
  - On that cycle, state -> DONE.
- DONE:
  - ResultValid = 1 and ResultOwner = Owner, both held stable until ResultReady.
  - ResultReady = 1 -> IDLE. No regrant in that same cycle, so there is one bubble cycle between operations.
- ReqReady is 0 outside IDLE. A request that is deasserted before its handshake is not remembered.
- Latency: handshake edge to ResultValid high = NUM_STAGES + ADD_CYCLES cycles.
- Throughput: at most one operation per NUM_STAGES + ADD_CYCLES + 2 cycles.
- Counters are exactly STAGE_W and 2 bits wide. They never wrap, because the exits occur at the terminal count.
- ResultReady while not in DONE is ignored.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined:
  - Adds input port OperandZero (2 bits, per-requester "either operand is zero") and output ZeroResult (1 bit).
  - If OperandZero[granted] is 1 at the handshake edge, the controller skips REDUCE and ADD and goes straight to DONE.
  - ResultLatch is not pulsed. ZeroResult = 1 while in that DONE.
  - Latency on this path is 1 cycle.
- Undefined:
  - Neither port exists. Every operation takes the full sequence.

Decomposition:
- Package mul_ctrl_pkg:
  - state enum (IDLE, REDUCE, ADD, DONE);
  - default constants MUL_NUM_STAGES = 7 and MUL_ADD_CYCLES = 2;
  - requester index constants REQ_MUL = 0 and REQ_AUX = 1.
- One sub-module, mul_rr_arbiter2:
  - combinational two-way round-robin grant from ReqValid and LastGrant;
  - LastGrant is updated in the parent on the handshake.

Test Plan:
- Reset, then ReqValid = 01 -> ReqReady = 01 and OperandLoad = 1 at edge 0. StageSel steps 0..6 on cycles 1-7. AddEn on cycles 8-9, ResultLatch on cycle 9. ResultValid on cycle 10 with ResultOwner = 0.
- ReqValid = 11 held for two operations -> first grant to 0, second grant to 1. After the bubble a third operation is granted to 0.
- In DONE, ResultReady held 0 for 5 cycles -> ResultValid stays 1, ResultOwner is constant and ReqReady = 00. ResultReady = 1 -> IDLE on the next edge.
- Reset pulsed while StageSel = 3 -> next edge: all outputs 0, Busy = 0, LastGrant = 1. A new request from requester 1 alone is granted immediately.
- With MUL_ZERO_SKIP_EN defined, OperandZero = 10 and ReqValid = 10 -> ResultValid 1 cycle after the handshake, ZeroResult = 1, StageEn and AddEn never asserted.
- ReqValid pulsed for 1 cycle while in REDUCE -> never granted. After the current operation's DONE, the arbiter returns to IDLE with ReqReady = 00.
